// File: rtl/mux_8x1_rr_collector_if.sv
// Bundle of the eight upstream valid/ready channels and the single tagged
// downstream stream of the round-robin collector.
interface mux_8x1_rr_collector_if #(
  parameter int unsigned DATA_W = 8
);
  logic [8*DATA_W-1:0] in_data;
  logic [7:0]          in_valid;
  logic [7:0]          in_last;
  logic [7:0]          in_ready;
  logic [DATA_W-1:0]   out_data;
  logic [2:0]          out_sel;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_sel, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_sel, out_last, out_valid
  );
endinterface

// File: rtl/mux_8x1_rr_collector.sv
// 8-to-1 packet-atomic round-robin collector with a registered, source-tagged
// output beat; a granted channel holds the output until its last beat.
module mux_8x1_rr_collector #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_8x1_rr_collector_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]        state;
  logic [2:0]        rr_ptr;
  logic [2:0]        lock_ch;
  logic [2:0]        grant;
  logic [2:0]        idx;
  logic [2:0]        sel;
  logic              found;
  logic              loadable;
  logic              capture;
  logic [7:0]        ready;
  logic [DATA_W-1:0] sel_data;

  logic [DATA_W-1:0] out_data_q;
  logic [2:0]        out_sel_q;
  logic              out_last_q;
  logic              out_valid_q;

  // First valid channel at or after rr_ptr, wrapping modulo 8.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = rr_ptr + 3'(i);
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // In LOCK the locked channel is offered regardless of its valid, so the
  // grant never depends on anything but state, out_valid and out_ready.
  always_comb begin
    loadable = !out_valid_q || bus.out_ready;
    sel      = (state == LOCK) ? lock_ch : grant;
    ready    = '0;
    if (loadable && (state == LOCK || found))
      ready[sel] = 1'b1;
    capture  = |(ready & bus.in_valid);
    sel_data = bus.in_data[sel*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lock_ch     <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (capture) begin
      out_data_q  <= sel_data;
      out_sel_q   <= sel;
      out_last_q  <= bus.in_last[sel];
      out_valid_q <= 1'b1;
      if (state == IDLE) begin
        rr_ptr <= grant + 3'd1;
        if (!bus.in_last[grant]) begin
          lock_ch <= grant;
          state   <= LOCK;
        end
      end else if (bus.in_last[lock_ch]) begin
        state <= IDLE;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_8x1_rr_collector.sv
// Directed and randomised checks of the 8-to-1 round-robin collector.
module tb_mux_8x1_rr_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  mux_8x1_rr_collector_if #(.DATA_W(8)) bus ();

  mux_8x1_rr_collector #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Soak scoreboard state
  logic [8:0] sb_q [8][$];
  int         seq [8];
  logic       pkt_open;
  logic [2:0] pkt_ch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = '0;
    bus.in_last  = '0;
    bus.in_data  = '0;
  endtask

  task automatic set_ch(input int k, input logic [7:0] d, input logic l);
    bus.in_valid[k]       = 1'b1;
    bus.in_data[k*8 +: 8] = d;
    bus.in_last[k]        = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Called mid-cycle with inputs settled: records handshakes on both sides.
  task automatic sb_sample();
    logic [7:0] acc;
    logic [2:0] c;
    logic [8:0] exp;
    check("t6_onehot0", 32'($onehot0(bus.in_ready)), 32'd1);
    if (bus.out_valid && bus.out_ready) begin
      c = bus.out_sel;
      if (pkt_open) check("t6_no_interleave", 32'(c), 32'(pkt_ch));
      check("t6_nonempty", 32'(sb_q[c].size() != 0), 32'd1);
      if (sb_q[c].size() != 0) begin
        exp = sb_q[c].pop_front();
        check("t6_beat", 32'({bus.out_last, bus.out_data}), 32'(exp));
      end
      pkt_open = !bus.out_last;
      pkt_ch   = c;
    end
    acc = bus.in_valid & bus.in_ready;
    for (int k = 0; k < 8; k++) begin
      if (acc[k]) begin
        sb_q[k].push_back({bus.in_last[k], bus.in_data[k*8 +: 8]});
        seq[k]++;
      end
    end
  endtask

  initial begin
    idle_inputs();
    bus.out_ready = 1'b0;

    // T1: reset in the middle of a locked packet
    do_reset();
    set_ch(2, 8'h22, 1'b0);
    step();
    check("t1_pre_valid", 32'(bus.out_valid), 32'd1);
    check("t1_pre_stall_ready", 32'(bus.in_ready), 32'h00);
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    check("t1_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t1_rst_sel", 32'(bus.out_sel), 32'd0);
    check("t1_rst_data", 32'(bus.out_data), 32'h00);
    check("t1_rst_last", 32'(bus.out_last), 32'd0);
    check("t1_rst_ready", 32'(bus.in_ready), 32'h00);
    set_ch(3, 8'h33, 1'b1);
    #1;
    check("t1_ch3_ready", 32'(bus.in_ready), 32'h08);
    step();
    check("t1_ch3_sel", 32'(bus.out_sel), 32'd3);
    check("t1_ch3_data", 32'(bus.out_data), 32'h33);
    idle_inputs();
    bus.out_ready = 1'b1;
    set_ch(2, 8'h22, 1'b1);
    set_ch(5, 8'h55, 1'b1);
    #1;
    check("t1_lock_dropped", 32'(bus.in_ready), 32'h20);

    // T2: all channels, single-beat packets, full throughput
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) set_ch(k, 8'(8'h10 + k), 1'b1);
    for (int i = 0; i < 9; i++) begin
      step();
      check("t2_sel", 32'(bus.out_sel), 32'(i % 8));
      check("t2_data", 32'(bus.out_data), 32'(8'h10 + i % 8));
      check("t2_valid", 32'(bus.out_valid), 32'd1);
    end

    // T3: ch2 four-beat packet while ch5 waits
    do_reset();
    bus.out_ready = 1'b1;
    set_ch(5, 8'h55, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      set_ch(2, 8'(8'h20 + j), (j == 4));
      #1;
      check("t3_lock_ready", 32'(bus.in_ready), 32'h04);
      step();
      check("t3_sel", 32'(bus.out_sel), 32'd2);
      check("t3_data", 32'(bus.out_data), 32'(8'h20 + j));
      check("t3_last", 32'(bus.out_last), 32'(j == 4));
    end
    #1;
    check("t3_next_ready", 32'(bus.in_ready), 32'h20);
    step();
    check("t3_next_sel", 32'(bus.out_sel), 32'd5);
    check("t3_next_data", 32'(bus.out_data), 32'h55);

    // T4: backpressure on a captured beat
    do_reset();
    set_ch(1, 8'hA5, 1'b1);
    step();
    set_ch(1, 8'h5A, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_stall_ready", 32'(bus.in_ready), 32'h00);
      check("t4_stall_data", 32'(bus.out_data), 32'hA5);
      check("t4_stall_sel", 32'(bus.out_sel), 32'd1);
      check("t4_stall_valid", 32'(bus.out_valid), 32'd1);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("t4_release_ready", 32'(bus.in_ready), 32'h02);
    step();
    check("t4_swap_data", 32'(bus.out_data), 32'h5A);
    check("t4_swap_valid", 32'(bus.out_valid), 32'd1);
    idle_inputs();
    step();
    check("t4_clear_valid", 32'(bus.out_valid), 32'd0);
    check("t4_hold_data", 32'(bus.out_data), 32'h5A);

    // T5: pointer wrap from 7 back to 0
    do_reset();
    bus.out_ready = 1'b1;
    set_ch(6, 8'h66, 1'b1);
    step();
    check("t5_first_sel", 32'(bus.out_sel), 32'd6);
    idle_inputs();
    set_ch(0, 8'h01, 1'b1);
    set_ch(7, 8'h77, 1'b1);
    #1;
    check("t5_ready_ch7", 32'(bus.in_ready), 32'h80);
    step();
    check("t5_sel_ch7", 32'(bus.out_sel), 32'd7);
    check("t5_ready_ch0", 32'(bus.in_ready), 32'h01);
    step();
    check("t5_sel_ch0", 32'(bus.out_sel), 32'd0);
    check("t5_data_ch0", 32'(bus.out_data), 32'h01);

    // T6: random soak against per-channel scoreboards
    do_reset();
    pkt_open = 1'b0;
    pkt_ch   = '0;
    for (int k = 0; k < 8; k++) seq[k] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < 8; k++) begin
        bus.in_valid[k]       = ($urandom_range(0, 3) != 0);
        bus.in_last[k]        = ($urandom_range(0, 2) == 0);
        bus.in_data[k*8 +: 8] = {3'(k), 5'(seq[k])};
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      sb_sample();
      step();
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      sb_sample();
      step();
    end
    for (int k = 0; k < 8; k++)
      check("t6_drained", 32'(sb_q[k].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
